multiword_add_seq: RTL
======================

# multiword_add_seq

Sequential multi-precision add/subtract engine that drives the 32-bit `Brent` adder one word per cycle. It chains the carry through a register to handle operands of `WORDS*N` bits. It accepts a full-width operand pair through a valid/ready handshake, processes the words LSW first, and presents the result with carry-out and signed overflow through a second valid/ready handshake. It sits directly upstream of the `Brent` adder, supplying its `A`/`B`/`Cin` and consuming its `Sum`, and is the datapath's wide-arithmetic front end.

## Interface
- `N`, 32: word width; must equal the `Brent` adder width.
- `WORDS`, 4: number of words per operand; legal range 1..16.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: engine can accept; high only in IDLE.
- `op_a`  in  `N*WORDS`: operand A, unsigned/two's-complement.
- `op_b`  in  `N*WORDS`: operand B.
- `sub`  in  1: 1 = A − B, 0 = A + B + `cin`.
- `cin`  in  1: carry-in for add; ignored when `sub`=1.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `result`  out  `N*WORDS`: sum/difference modulo 2^(N*WORDS).
- `cout`  out  1: final carry (for subtract, 1 = no borrow).
- `ovf`  out  1: signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE. The state at reset is IDLE.
- IDLE: `in_ready`=1. When `in_valid`=1, the block latches `op_a`, `op_b` pre-inverted when `sub`=1, and `c0 = sub ? 1 : cin`. It then clears `idx` and goes to RUN.
- RUN, word `idx`:
  - Adder inputs: `A = a[idx]`, `B = b'[idx]`, `Cin = (idx==0) ? c0 : carry_q`.
  - At the edge: `result[idx] <= Sum[N-1:0]`, `carry_q <= Sum[N]`, `idx <= idx+1`.
  - On the last word (`idx==WORDS-1`), the block also loads `cout <= Sum[N]` and `ovf <= (a_msb == b'_msb) && (Sum[N-1] != a_msb)`, then goes to DONE.
- DONE: `out_valid`=1. `result`, `cout` and `ovf` hold stable until `out_ready`=1, then the FSM returns to IDLE. `out_valid` drops on that same edge.
- `in_valid` outside IDLE is ignored; `in_ready`=0 there. `out_ready` outside DONE is ignored.
- Widths: `idx` is `$clog2(WORDS)` bits, minimum 1. Word slices are `[idx*N +: N]`. No arithmetic wider than `N+1` bits exists outside the adder.
- Reset values: `out_valid`=0, `result`=0, `cout`=0, `ovf`=0, `idx`=0, `carry_q`=0, operand registers 0, `in_ready`=1 (combinational from IDLE).
- Reset asserted mid-RUN or in DONE aborts immediately. All outputs take their reset values asynchronously, and the pending result is discarded.
- With `WORDS`=1, RUN lasts one cycle and the block behaves as a registered single-word add.

## Timing
- Accept edge E0 (IDLE→RUN). Word k is written at edge E(k+1). `out_valid` is high after edge E(WORDS): latency is `WORDS` cycles from accept to `out_valid`.
- If `out_ready`=1 while `out_valid`=1, the handshake completes at that edge. `in_ready` rises the following cycle.
- Minimum issue interval is `WORDS+2` cycles with `out_ready` tied high.
- Adder path is combinational within one cycle: from the operand/`carry_q` registers, through `Brent`, to the `result`/`carry_q` registers.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.

## Structure
- Shared package holds:
  - `N`, `WORDS_MAX` (16);
  - the `idx` width function;
  - the state enum {IDLE, RUN, DONE}.
- One sub-module: the existing `Brent` adder, instantiated once with `N`=32. Its `Sum[N]` is the word carry-out.
- Operand storage is a pair of `N*WORDS` registers indexed by `idx`. Shift registers are not used, so `result` word positions stay fixed.

## Test plan
- `WORDS`=4, `op_a`=2^128−1, `op_b`=1, `sub`=0, `cin`=0 → `result`=0, `cout`=1, `ovf`=0, `out_valid` exactly 4 cycles after accept.
- `op_a`=0x00000000_00000000_00000000_FFFFFFFF, `op_b`=1 → `result`=0x00000000_00000000_00000001_00000000, `cout`=0; checks the word-to-word carry chain.
- `op_a`=5, `op_b`=7, `sub`=1 → `result`=2^128−2, `cout`=0 (borrow), `ovf`=0; the same with `cin`=1 gives an identical result (`cin` ignored).
- `op_a`=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, `op_b`=1, add → `result`=0x80000000_00000000_00000000_00000000, `ovf`=1, `cout`=0.
- Hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands → `result`, `cout`, `ovf` stable, `in_ready`=0, no new op accepted; after release, `in_ready`=1 next cycle.
- Assert `rst_n`=0 while `idx`=2 → outputs go to reset values asynchronously and `in_ready`=1. After release, 1+1 yields `result`=2 with `out_valid` 4 cycles after accept.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared constants, state encoding and index-width helper for the multi-word add/sub engine.
package multiword_add_seq_pkg;

    localparam int N         = 32;
    localparam int WORDS_MAX = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/Brent.sv
// Brent-Kung parallel-prefix adder: Sum[N-1:0] is the word sum, Sum[N] the carry-out.
module Brent #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N:0]   Sum
);

    localparam int DS = (N >= 4) ? (1 << ($clog2(N) - 2)) : 0;

    always_comb begin
        logic [N-1:0] g, p, gg, pp;
        g  = A & B;
        p  = A ^ B;
        gg = g;
        pp = p;
        // Fold Cin into bit 0 so every prefix gg[i] is the carry out of bit i.
        gg[0] = g[0] | (p[0] & Cin);
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = DS; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        Sum    = '0;
        Sum[0] = p[0] ^ Cin;
        for (int i = 1; i < N; i++) begin
            Sum[i] = p[i] ^ gg[i-1];
        end
        Sum[N] = gg[N-1];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial multi-precision add/subtract: one N-bit word per cycle through a shared
// Brent adder, LSW first, carry chained through carry_q.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int N     = multiword_add_seq_pkg::N,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] op_a,
    input  logic [N*WORDS-1:0] op_b,
    input  logic               sub,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf
);

    localparam int IW = idx_w(WORDS);
    localparam int W  = N * WORDS;

    state_t        state;
    logic [W-1:0]  a_q, b_q;
    logic          c0_q, carry_q;
    logic [IW-1:0] idx_q;

    logic [N-1:0]  add_a, add_b;
    logic          add_cin;
    logic [N:0]    add_sum;
    logic          last;

    assign add_a    = a_q[int'(idx_q)*N +: N];
    assign add_b    = b_q[int'(idx_q)*N +: N];
    assign add_cin  = (idx_q == '0) ? c0_q : carry_q;
    assign last     = (int'(idx_q) == WORDS - 1);
    assign in_ready = (state == IDLE);

    Brent #(.N(N)) u_adder (
        .A   (add_a),
        .B   (add_b),
        .Cin (add_cin),
        .Sum (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c0_q      <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so B is inverted once at capture.
                        a_q   <= op_a;
                        b_q   <= sub ? ~op_b : op_b;
                        c0_q  <= sub | cin;
                        idx_q <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[int'(idx_q)*N +: N] <= add_sum[N-1:0];
                    carry_q <= add_sum[N];
                    idx_q   <= idx_q + IW'(1);
                    if (last) begin
                        cout      <= add_sum[N];
                        ovf       <= (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
